uart_tx_serializer: RTL and testbench

//   UART transmit serializer; sits directly downstream of uart_tx_buffer and consumes its txStart/txData.

---
 rtl/uart_tx_serializer_pkg.sv | 7 +
 rtl/uart_tx_serializer_baud_tick.sv | 17 +
 rtl/uart_tx_serializer.sv | 91 +++++++++
 tb/tb_uart_tx_serializer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_serializer_pkg.sv
// uart_tx_serializer_pkg: shared FSM states and parity modes for the UART TX/RX paths
package uart_tx_serializer_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} txState_t;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD = 2;
endpackage

// File: rtl/uart_tx_serializer_baud_tick.sv
// uart_baud_tick: bit-period counter, tick high on the last cycle of each bit
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] TERM = W'(CLKS_PER_BIT - 1);
  logic [W-1:0] cnt;
  always_comb tick = cnt == TERM;
  always_ff @(posedge clk)
    if (rst || restart) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: start bit, 8 data bits LSB first, optional parity, 1-2 stop bits
module uart_tx_serializer
  import uart_tx_serializer_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
  parameter int PARITY = PARITY_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       txStart,
  input  logic [7:0] txData,
  output logic       txBusy,
  output logic       txDone,
  output logic       tx
);
  txState_t state;
  logic [7:0] shiftReg;
  logic [2:0] bitIdx;
  logic parityAcc;
  logic tick;
  logic restart;
  always_comb restart = state == IDLE;
  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) baudTick (
    .clk(clk),
    .rst(rst),
    .restart(restart),
    .tick(tick)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      tx <= 1'b1;
      txBusy <= 1'b0;
      txDone <= 1'b0;
      bitIdx <= '0;
      shiftReg <= '0;
      parityAcc <= 1'b0;
    end else begin
      txDone <= 1'b0;
      case (state)
        IDLE:
          if (txStart) begin
            shiftReg <= txData;
            tx <= 1'b0;
            txBusy <= 1'b1;
            state <= START;
          end
        START:
          if (tick) begin
            tx <= shiftReg[0];
            parityAcc <= shiftReg[0];
            shiftReg <= {1'b0, shiftReg[7:1]};
            bitIdx <= '0;
            state <= DATA;
          end
        DATA:
          if (tick) begin
            if (bitIdx == 3'd7) begin
              bitIdx <= '0;
              tx <= (PARITY != PARITY_NONE) ? parityAcc ^ (PARITY == PARITY_ODD) : 1'b1;
              state <= (PARITY != PARITY_NONE) ? PAR : STOP;
            end else begin
              tx <= shiftReg[0];
              parityAcc <= parityAcc ^ shiftReg[0];
              shiftReg <= {1'b0, shiftReg[7:1]};
              bitIdx <= bitIdx + 3'd1;
            end
          end
        PAR:
          if (tick) begin
            tx <= 1'b1;
            bitIdx <= '0;
            state <= STOP;
          end
        STOP:
          if (tick) begin
            // bitIdx reused to count stop-bit periods
            if (bitIdx == 3'(STOP_BITS - 1)) begin
              txBusy <= 1'b0;
              txDone <= 1'b1;
              bitIdx <= '0;
              state <= IDLE;
            end else bitIdx <= bitIdx + 3'd1;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: three parity/stop configurations checked against a frame-level model
module tb_uart_tx_serializer;
  localparam int C = 4;
  localparam int PARS[3] = '{0, 1, 2};
  localparam int STOPS[3] = '{1, 2, 1};
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic txStart = 1'b0;
  logic [7:0] txData = 8'h00;
  logic [2:0] txV, busyV, doneV;
  logic [2:0] expTx, expBusy, expDone;
  logic [2:0] mBusy;
  int mPos[3];
  logic [7:0] mData[3];
  int vec = 0;
  int miss = 0;
  int sample = 0;
  int busyCnt[3];
  int doneCnt[3];
  always #5 clk = ~clk;
  uart_tx_serializer #(.CLKS_PER_BIT(C), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .txStart(txStart), .txData(txData),
    .txBusy(busyV[0]), .txDone(doneV[0]), .tx(txV[0]));
  uart_tx_serializer #(.CLKS_PER_BIT(C), .PARITY(1), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst(rst), .txStart(txStart), .txData(txData),
    .txBusy(busyV[1]), .txDone(doneV[1]), .tx(txV[1]));
  uart_tx_serializer #(.CLKS_PER_BIT(C), .PARITY(2), .STOP_BITS(1)) dut2 (
    .clk(clk), .rst(rst), .txStart(txStart), .txData(txData),
    .txBusy(busyV[2]), .txDone(doneV[2]), .tx(txV[2]));
  function automatic int frameLen(input int par, input int stops);
    return (1 + 8 + (par != 0 ? 1 : 0) + stops) * C;
  endfunction
  // Line level of bit slot idx in a frame: start, data LSB first, parity, stop
  function automatic logic frameBit(input logic [7:0] d, input int par, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (par != 0 && idx == 9) return (^d) ^ (par == 2);
    return 1'b1;
  endfunction
  always @(posedge clk)
    for (int k = 0; k < 3; k++) begin
      expDone[k] = 1'b0;
      if (rst) begin
        mBusy[k] = 1'b0;
        expTx[k] = 1'b1;
        expBusy[k] = 1'b0;
      end else if (mBusy[k]) begin
        if (mPos[k] == frameLen(PARS[k], STOPS[k])) begin
          mBusy[k] = 1'b0;
          expBusy[k] = 1'b0;
          expDone[k] = 1'b1;
          expTx[k] = 1'b1;
        end else begin
          expTx[k] = frameBit(mData[k], PARS[k], mPos[k] / C);
          mPos[k]++;
        end
      end else if (txStart) begin
        mData[k] = txData;
        mBusy[k] = 1'b1;
        expBusy[k] = 1'b1;
        expTx[k] = 1'b0;
        mPos[k] = 1;
      end
    end
  task automatic chk(input string tag, input int k, input int got, input int exp);
    vec++;
    assert (got === exp) else begin
      miss++;
      $error("FAIL %s[dut%0d] t=%0t got %0d expected %0d", tag, k, $time, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    sample++;
    for (int k = 0; k < 3; k++) begin
      chk("tx", k, int'(txV[k]), int'(expTx[k]));
      chk("txBusy", k, int'(busyV[k]), int'(expBusy[k]));
      chk("txDone", k, int'(doneV[k]), int'(expDone[k]));
      if (busyV[k]) busyCnt[k]++;
      if (doneV[k]) doneCnt[k]++;
    end
  endtask
  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask
  task automatic waitIdle(input int limit);
    int n = 0;
    while ((busyV != 3'b000 || mBusy != 3'b000) && n < limit) begin
      step();
      n++;
    end
    vec++;
    assert (n < limit) else begin
      miss++;
      $error("FAIL idle_timeout busy=%b model=%b waited %0d limit %0d", busyV, mBusy, n, limit);
    end
  endtask
  task automatic sendPulse(input logic [7:0] d);
    txData = d;
    txStart = 1'b1;
    step();
    txStart = 1'b0;
  endtask
  task automatic clearCounts();
    for (int k = 0; k < 3; k++) begin
      busyCnt[k] = 0;
      doneCnt[k] = 0;
    end
  endtask
  initial begin
    int firstStart, secondStart, idleRun;
    mBusy = 3'b000;
    clearCounts();
    steps(2);
    rst = 1'b0;
    steps(20);
    clearCounts();
    sendPulse(8'h41);
    waitIdle(100);
    steps(3);
    for (int k = 0; k < 3; k++) begin
      chk("busy_len_41", k, busyCnt[k], frameLen(PARS[k], STOPS[k]));
      chk("done_cnt_41", k, doneCnt[k], 1);
    end
    sendPulse(8'h43);
    steps(37);
    step();
    chk("parity_even_43", 1, int'(txV[1]), 1);
    chk("parity_odd_43", 2, int'(txV[2]), 0);
    waitIdle(100);
    steps(2);
    clearCounts();
    sendPulse(8'h44);
    steps(9);
    txData = 8'h55;
    txStart = 1'b1;
    step();
    txStart = 1'b0;
    waitIdle(100);
    steps(60);
    for (int k = 0; k < 3; k++) chk("single_frame_44", k, doneCnt[k], 1);
    clearCounts();
    txData = 8'h45;
    txStart = 1'b1;
    step();
    firstStart = sample;
    secondStart = -1;
    idleRun = 0;
    while (doneCnt[0] < 2 && idleRun < 200) begin
      step();
      idleRun++;
      if (doneV[0]) txData = 8'h46;
      if (secondStart < 0 && doneCnt[0] == 1 && busyV[0]) secondStart = sample;
    end
    txStart = 1'b0;
    chk("back_to_back_gap", 0, secondStart - firstStart, frameLen(0, 1) + 1);
    waitIdle(200);
    steps(3);
    clearCounts();
    sendPulse(8'h4A);
    steps(16);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("abort_tx", k, int'(txV[k]), 1);
      chk("abort_busy", k, int'(busyV[k]), 0);
    end
    steps(10);
    for (int k = 0; k < 3; k++) chk("abort_no_done", k, doneCnt[k], 0);
    sendPulse(8'h4A);
    waitIdle(100);
    steps(2);
    for (int k = 0; k < 3; k++) chk("after_abort_done", k, doneCnt[k], 1);
    for (int f = 0; f < 25; f++) begin
      for (int g = int'($urandom_range(0, 5)); g > 0; g--) begin
        txData = 8'($urandom);
        step();
      end
      txData = 8'($urandom);
      txStart = 1'b1;
      steps(int'($urandom_range(1, 3)));
      txStart = 1'b0;
      for (int b = 0; b < 12; b++) begin
        txData = 8'($urandom);
        txStart = ($urandom_range(0, 7) == 0);
        step();
      end
      txStart = 1'b0;
      waitIdle(200);
    end
    steps(5);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
